shift_rr_seq: RTL and testbench

- Multi-cycle right-direction shifter/rotator for the 16-bit datapath: ROR, SRL and SRA by a 4-bit amount.
- Processes one power-of-two stage per clock (shift by 1, 2, 4, 8) through a registered datapath.
- Uses a start/busy/done handshake. Pairs with the existing left-rotate stages; sits beside the ALU as the shift/rotate execution resource.

---
 rtl/shift_rr_seq_pkg.sv | 14 +
 rtl/shift_rr_seq_stage.sv | 26 ++
 rtl/shift_rr_seq.sv | 87 ++++++++
 tb/tb_shift_rr_seq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/shift_rr_seq_pkg.sv
// Shared encodings for the multi-cycle right shift/rotate unit.
package shift_rr_seq_pkg;

  localparam logic [1:0] OP_ROR = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  localparam int STAGES = 4;

endpackage

// File: rtl/shift_rr_seq_stage.sv
// Combinational single-stage right shift/rotate by a fixed amount AMT.
module rr_stage
  import shift_rr_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT   = 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       op,
  input  logic             en,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = din;
    if (en) begin
      case (op)
        OP_SRL:  dout = {{AMT{1'b0}}, din[WIDTH-1:AMT]};
        OP_SRA:  dout = {{AMT{din[WIDTH-1]}}, din[WIDTH-1:AMT]};
        // Reserved encoding behaves as ROR.
        default: dout = {din[AMT-1:0], din[WIDTH-1:AMT]};
      endcase
    end
  end

endmodule

// File: rtl/shift_rr_seq.sv
// Multi-cycle ROR/SRL/SRA unit: one power-of-two stage per clock, start/busy/done handshake.
module shift_rr_seq
  import shift_rr_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] In,
  input  logic [CNT_W-1:0] Cnt,
  input  logic [1:0]       Op,
  output logic [WIDTH-1:0] Out,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       stage_q, stage_d;

  logic [WIDTH-1:0] stage_out [STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    rr_stage #(.WIDTH(WIDTH), .AMT(1 << i)) u_stage (
      .din  (out_q),
      .op   (op_q),
      .en   (cnt_q[i]),
      .dout (stage_out[i])
    );
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    stage_d = stage_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          out_d   = In;
          cnt_d   = Cnt;
          op_d    = Op;
          stage_d = 2'd0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Always walk all four stages so latency is independent of Cnt.
        out_d = stage_out[stage_q];
        if (stage_q == 2'd3) begin
          stage_d = 2'd0;
          state_d = ST_DONE;
        end else begin
          stage_d = stage_q + 2'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      stage_q <= stage_d;
    end
  end

  assign Out  = out_q;
  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_rr_seq.sv
// Directed self-checking bench for shift_rr_seq.
module tb_shift_rr_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] In = '0;
  logic [3:0]  Cnt = '0;
  logic [1:0]  Op = '0;
  logic [15:0] Out;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  shift_rr_seq #(.WIDTH(16), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .In    (In),
    .Cnt   (Cnt),
    .Op    (Op),
    .Out   (Out),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Issue one operation and observe 12 cycles; cycle i is the one after edge k+i-1.
  task automatic run_op(input logic [15:0] a, input logic [3:0] c, input logic [1:0] o,
                        output logic [15:0] res, output int busy_n,
                        output int done_at, output int done_n);
    busy_n = 0; done_at = -1; done_n = 0; res = 16'hxxxx;
    @(negedge clk);
    In = a; Cnt = c; Op = o; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; In = 16'hDEAD; Cnt = 4'hF; Op = 2'b01;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = i;
          res = Out;
        end
      end
    end
    if (done_at < 0) res = Out;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (Out !== 16'h0000) begin fails++; $display("FAIL reset_out got=%h exp=0000", Out); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ror();
    logic [15:0] r; int bn, da, dn;
    run_op(16'h8001, 4'd1, 2'b00, r, bn, da, dn);
    tests++; if (r !== 16'hC000) begin fails++; $display("FAIL ror_8001_1 got=%h exp=c000", r); end
    tests++; if (da !== 5) begin fails++; $display("FAIL ror_latency got=%0d exp=5", da); end
    tests++; if (bn !== 4) begin fails++; $display("FAIL ror_busy_cycles got=%0d exp=4", bn); end
    tests++; if (dn !== 1) begin fails++; $display("FAIL ror_done_pulses got=%0d exp=1", dn); end
    run_op(16'h1234, 4'd4, 2'b00, r, bn, da, dn);
    tests++; if (r !== 16'h4123) begin fails++; $display("FAIL ror_1234_4 got=%h exp=4123", r); end
    run_op(16'h1234, 4'd0, 2'b00, r, bn, da, dn);
    tests++; if (r !== 16'h1234) begin fails++; $display("FAIL ror_1234_0 got=%h exp=1234", r); end
    tests++; if (bn !== 4) begin fails++; $display("FAIL ror_cnt0_busy got=%0d exp=4", bn); end
    tests++; if (da !== 5) begin fails++; $display("FAIL ror_cnt0_latency got=%0d exp=5", da); end
  endtask

  task automatic test_srl_sra();
    logic [15:0] r; int bn, da, dn;
    run_op(16'h8000, 4'd15, 2'b01, r, bn, da, dn);
    tests++; if (r !== 16'h0001) begin fails++; $display("FAIL srl_8000_15 got=%h exp=0001", r); end
    run_op(16'h8000, 4'd15, 2'b10, r, bn, da, dn);
    tests++; if (r !== 16'hFFFF) begin fails++; $display("FAIL sra_8000_15 got=%h exp=ffff", r); end
    run_op(16'h7FF0, 4'd4, 2'b10, r, bn, da, dn);
    tests++; if (r !== 16'h07FF) begin fails++; $display("FAIL sra_7ff0_4 got=%h exp=07ff", r); end
    // Out must hold while idle even as inputs move.
    In = 16'h1111;
    repeat (3) @(negedge clk);
    tests++; if (Out !== 16'h07FF) begin fails++; $display("FAIL idle_hold got=%h exp=07ff", Out); end
  endtask

  task automatic test_reserved();
    logic [15:0] r; int bn, da, dn;
    run_op(16'h00F1, 4'd8, 2'b11, r, bn, da, dn);
    tests++; if (r !== 16'hF100) begin fails++; $display("FAIL op11_as_ror got=%h exp=f100", r); end
  endtask

  task automatic test_start_while_busy();
    int dn; logic [15:0] r;
    dn = 0; r = 16'hxxxx;
    @(negedge clk);
    In = 16'hAAAA; Cnt = 4'd1; Op = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    In = 16'hFFFF; Cnt = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin dn++; r = Out; end
      @(negedge clk);
    end
    tests++; if (r !== 16'h5555) begin fails++; $display("FAIL busy_ignore_out got=%h exp=5555", r); end
    tests++; if (dn !== 1) begin fails++; $display("FAIL busy_ignore_pulses got=%0d exp=1", dn); end
  endtask

  task automatic test_back_to_back();
    int guard;
    guard = 0;
    @(negedge clk);
    In = 16'h0F00; Cnt = 4'd8; Op = 2'b01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && guard < 10) begin @(negedge clk); guard++; end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_first_done got=%b exp=1", done); end
    // Start raised during DONE is ignored; held high it is taken the cycle after.
    In = 16'h00F0; Cnt = 4'd4; Op = 2'b00; start = 1'b1;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL done_start_ignored busy=%b exp=0", busy); end
    tests++; if (Out !== 16'h000F) begin fails++; $display("FAIL b2b_first_out got=%h exp=000f", Out); end
    @(negedge clk);
    start = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept busy=%b exp=1", busy); end
    repeat (4) @(negedge clk);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_second_done got=%b exp=1", done); end
    tests++; if (Out !== 16'h000F) begin fails++; $display("FAIL b2b_second_out got=%h exp=000f", Out); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] r; int bn, da, dn, dcount;
    dcount = 0;
    @(negedge clk);
    In = 16'h1234; Cnt = 4'd3; Op = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (Out !== 16'h0000) begin fails++; $display("FAIL midrst_out got=%h exp=0000", Out); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    tests++; if (dcount !== 0) begin fails++; $display("FAIL midrst_no_done got=%0d exp=0", dcount); end
    run_op(16'h00F1, 4'd4, 2'b00, r, bn, da, dn);
    tests++; if (r !== 16'h100F) begin fails++; $display("FAIL after_rst_out got=%h exp=100f", r); end
    tests++; if (da !== 5) begin fails++; $display("FAIL after_rst_latency got=%0d exp=5", da); end
  endtask

  initial begin
    test_reset();
    test_ror();
    test_srl_sra();
    test_reserved();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
